onehot_scan_decoder: RTL and testbench

//   Registered, parametrised N-to-2^N one-hot decoder with two modes.
//   - Direct mode: loads a select value through a valid/ready handshake.
//   - Scan mode: walks the active output bit round-robin, with a programmable dwell per step.

---
 rtl/onehot_dec_pkg.sv | 35 +++
 rtl/onehot_scan_decoder_dwell_timer.sv | 41 ++++
 rtl/onehot_scan_decoder.sv | 146 ++++++++++++++
 tb/tb_onehot_scan_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/onehot_dec_pkg.sv
// ---------------------------------------------------------------------------
// Package: onehot_dec_pkg
// Purpose: Shared types and helpers for the one-hot scan decoder.
//   - mode_e  : DIRECT (load through handshake) or SCAN (round-robin walk)
//   - state_e : controller states, ST_BLANK only reached when the build
//               defines ONEHOT_SCAN_BLANKING_EN
//   - onehot(): index to one-hot vector at the widest supported size; the
//               caller narrows the result to its own output width
// ---------------------------------------------------------------------------
package onehot_dec_pkg;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN,
    ST_BLANK
  } state_e;

  // Widest-case decode so one function serves every SEL_W up to MAX_SEL_W.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    logic [MAX_OUT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_dwell_timer.sv
// ---------------------------------------------------------------------------
// Module: dwell_timer
// Purpose: Counts 0..DWELL-1 while enabled and flags the terminal count, so
//          the decoder knows when the current scan index has been shown long
//          enough.
// Ports:
//   i_clk     in  clock, rising edge
//   i_rst_n   in  asynchronous active-low reset
//   i_clear   in  synchronous clear to zero (wins over enable)
//   i_enable  in  advance the count this cycle
//   o_tc      out high in the enabled cycle whose count is DWELL-1
// ---------------------------------------------------------------------------
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_count;

  assign o_tc = i_enable && (r_count == TC_VAL);

  // Terminal count folds back to zero so DWELL need not be a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_tc ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// ---------------------------------------------------------------------------
// Module: onehot_scan_decoder
// Purpose: Registered SEL_W-to-2^SEL_W one-hot decoder for display row/digit
//          enables and time-sliced peripheral selects.
//   DIRECT mode loads an index through a valid/ready handshake (latency 1).
//   SCAN mode walks the active bit 0..LAST, holding each index DWELL cycles
//   and pulsing o_wrap when the walk returns to 0.
// Ports:
//   i_clk        in   clock, rising edge
//   i_rst_n      in   asynchronous active-low reset
//   i_en         in   global enable, 0 forces o_y to zero next cycle
//   i_mode       in   0 = DIRECT, 1 = SCAN
//   i_sel_valid  in   direct-mode index valid
//   i_sel        in   direct-mode index
//   o_sel_ready  out  index accepted this cycle when valid
//   o_y          out  one-hot output or all-zero
//   o_idx        out  index currently (or last) selected
//   o_wrap       out  one-cycle pulse when the scan wraps LAST -> 0
// Build option:
//   ONEHOT_SCAN_BLANKING_EN adds break-before-make blanking: a direct index
//   change shows one all-zero cycle first, and in scan mode the first cycle
//   of every dwell interval is all-zero.
// ---------------------------------------------------------------------------
module onehot_scan_decoder
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 4,
  parameter int LAST  = (1 << SEL_W) - 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_sel_valid,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_sel_ready,
  output logic [(1<<SEL_W)-1:0] o_y,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_wrap
);

  localparam int OUT_W = 1 << SEL_W;

`ifdef ONEHOT_SCAN_BLANKING_EN
  localparam bit BLANKING = 1'b1;
`else
  localparam bit BLANKING = 1'b0;
`endif

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i);
    return OUT_W'(onehot(MAX_SEL_W'(i)));
  endfunction

  state_e           r_state;
  logic [OUT_W-1:0] r_y;
  logic [SEL_W-1:0] r_idx;
  logic             r_wrap;

  mode_e            w_mode;
  logic             w_scanRun;
  logic             w_tc;
  logic             w_atLast;
  logic [SEL_W-1:0] w_entryIdx;
  logic [SEL_W-1:0] w_stepIdx;

  assign w_mode    = mode_e'(i_mode);

  // The dwell timer only runs while scanning continues; any exit clears it,
  // so every scan entry starts a fresh, full dwell interval.
  assign w_scanRun = (r_state == ST_SCAN) && i_en && (w_mode == MODE_SCAN);

  // Index arithmetic wraps at LAST, not at the natural SEL_W rollover.
  assign w_atLast   = (int'(r_idx) >= LAST);
  assign w_entryIdx = (int'(r_idx) <= LAST) ? r_idx : '0;
  assign w_stepIdx  = w_atLast ? '0 : r_idx + 1'b1;

  // Ready is withheld whenever the transfer would be thrown away (disable,
  // pending mode switch, blank cycle, or the IDLE->DIRECT cycle).
  assign o_sel_ready = (r_state == ST_DIRECT) && i_en && (w_mode == MODE_DIRECT);

  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (!w_scanRun),
    .i_enable(w_scanRun),
    .o_tc    (w_tc)
  );

  // Controller: en has top priority, then the requested mode; within DIRECT
  // the state decides between finishing a blank and taking a new index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_y     <= '0;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (!i_en) begin
        r_state <= ST_IDLE;
        r_y     <= '0;
      end else if (w_mode == MODE_SCAN) begin
        if (r_state != ST_SCAN) begin
          r_state <= ST_SCAN;
          r_idx   <= w_entryIdx;
          r_y     <= BLANKING ? '0 : decode(w_entryIdx);
        end else if (w_tc) begin
          r_idx  <= w_stepIdx;
          r_wrap <= w_atLast;
          r_y    <= BLANKING ? '0 : decode(w_stepIdx);
        end else begin
          r_y <= decode(r_idx);
        end
      end else begin
        case (r_state)
          ST_IDLE, ST_SCAN: begin
            r_state <= ST_DIRECT;
          end
          ST_BLANK: begin
            r_state <= ST_DIRECT;
            r_y     <= decode(r_idx);
          end
          default: begin
            if (i_sel_valid) begin
              r_idx <= i_sel;
              if (BLANKING && (i_sel != r_idx)) begin
                r_state <= ST_BLANK;
                r_y     <= '0;
              end else begin
                r_y <= decode(i_sel);
              end
            end
          end
        endcase
      end
    end
  end

  assign o_y    = r_y;
  assign o_idx  = r_idx;
  assign o_wrap = r_wrap;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// ---------------------------------------------------------------------------
// Testbench: tb_onehot_scan_decoder
// Drives onehot_scan_decoder (SEL_W=3, DWELL=4, LAST=5) with directed and
// randomized steps and compares every cycle against a behavioural model.
// Honors ONEHOT_SCAN_BLANKING_EN when the build defines it.
// ---------------------------------------------------------------------------
module tb_onehot_scan_decoder;

  localparam int SEL_W = 3;
  localparam int DWELL = 4;
  localparam int LAST  = 5;

`ifdef ONEHOT_SCAN_BLANKING_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       en        = 1'b0;
  logic       mode      = 1'b0;
  logic       sel_valid = 1'b0;
  logic [2:0] sel       = 3'd0;
  logic       sel_ready;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;

  always #5 clk = ~clk;

  onehot_scan_decoder #(
    .SEL_W(SEL_W),
    .DWELL(DWELL),
    .LAST (LAST)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_mode     (mode),
    .i_sel_valid(sel_valid),
    .i_sel      (sel),
    .o_sel_ready(sel_ready),
    .o_y        (y),
    .o_idx      (idx),
    .o_wrap     (wrap)
  );

  int testCount = 0;
  int failCount = 0;

  // Behavioural model: 0 = idle, 1 = direct, 2 = scan; mAge counts cycles
  // spent on the current scan index, mBlank marks a pending direct blank.
  int         mState;
  int         mIdx;
  int         mAge;
  bit         mBlank;
  bit         mWrap;
  logic [7:0] mY;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mState = 0;
    mIdx   = 0;
    mAge   = 0;
    mBlank = 1'b0;
    mWrap  = 1'b0;
    mY     = 8'h00;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic modelStep();
    mWrap = 1'b0;
    if (!en) begin
      mState = 0;
      mY     = 8'h00;
      mAge   = 0;
      mBlank = 1'b0;
    end else if (mode) begin
      if (mState != 2) begin
        mState = 2;
        mBlank = 1'b0;
        if (mIdx > LAST) mIdx = 0;
        mAge = 0;
        mY   = BLANK ? 8'h00 : 8'(1 << mIdx);
      end else begin
        mAge++;
        if (mAge == DWELL) begin
          mAge  = 0;
          mWrap = (mIdx == LAST);
          mIdx  = (mIdx + 1) % (LAST + 1);
          mY    = BLANK ? 8'h00 : 8'(1 << mIdx);
        end else begin
          mY = 8'(1 << mIdx);
        end
      end
    end else begin
      if (mState != 1) begin
        mState = 1;
        mBlank = 1'b0;
      end else if (mBlank) begin
        mBlank = 1'b0;
        mY     = 8'(1 << mIdx);
      end else if (sel_valid) begin
        if (BLANK && (int'(sel) != mIdx)) begin
          mIdx   = int'(sel);
          mY     = 8'h00;
          mBlank = 1'b1;
        end else begin
          mIdx = int'(sel);
          mY   = 8'(1 << mIdx);
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkEq("y", 32'(y), 32'(mY));
    checkEq("idx", 32'(idx), 32'(mIdx));
    checkEq("wrap", 32'(wrap), 32'(mWrap));
    checkEq("onehot_or_zero", 32'($countones(y) <= 1), 32'd1);
  endtask

  task automatic applyStimulus(input bit e, input bit m, input bit v, input logic [2:0] s);
    en        = e;
    mode      = m;
    sel_valid = v;
    sel       = s;
    #1;
    checkEq("sel_ready", 32'(sel_ready), 32'(mState == 1 && !mBlank && e && !m));
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  bit curMode;

  initial begin
    modelReset();

    // Asynchronous reset with no clock edge needed.
    #2 rst_n = 1'b0;
    #1;
    checkOutput();
    checkEq("reset_sel_ready", 32'(sel_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Direct load of 3: first cycle only leaves IDLE, then the transfer lands.
    applyStimulus(1, 0, 1, 3'd3);
    applyStimulus(1, 0, 1, 3'd3);
    repeat (3) applyStimulus(1, 0, 0, 3'd5);

    // Direct sweep of every index.
    for (int s = 0; s < 8; s++) begin
      applyStimulus(1, 0, 1, 3'(s));
      if (BLANK) applyStimulus(1, 0, 0, 3'(s));
    end

    // Random direct traffic.
    repeat (24) applyStimulus(1, 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    // Full scan from index 0 through the wrap, with sel_valid ignored.
    applyStimulus(1, 0, 1, 3'd0);
    applyStimulus(1, 0, 0, 3'd0);
    repeat (30) applyStimulus(1, 1, 1, 3'($urandom_range(0, 7)));

    // Drop en mid-dwell at index 2, then resume with a full dwell.
    applyStimulus(1, 0, 1, 3'd0);
    applyStimulus(1, 0, 0, 3'd0);
    repeat (10) applyStimulus(1, 1, 0, 3'd0);
    repeat (2) applyStimulus(0, 1, 0, 3'd0);
    repeat (6) applyStimulus(1, 1, 0, 3'd0);

    // Scan entry from an index above LAST starts at 0.
    applyStimulus(1, 0, 1, 3'd7);
    applyStimulus(1, 0, 0, 3'd7);
    repeat (6) applyStimulus(1, 1, 0, 3'd7);

    // Break-before-make sample: 1 -> 6 in direct mode.
    applyStimulus(1, 0, 1, 3'd1);
    applyStimulus(1, 0, 1, 3'd1);
    applyStimulus(1, 0, 1, 3'd6);
    applyStimulus(1, 0, 0, 3'd6);

    // Randomized mixed traffic with sticky mode and occasional disable.
    curMode = 1'b0;
    repeat (300) begin
      if ($urandom_range(0, 11) == 0) curMode = ~curMode;
      applyStimulus(1'($urandom_range(0, 9) != 0), curMode,
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    // Reset asserted mid-scan between clock edges.
    repeat (7) applyStimulus(1, 1, 0, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    #2 rst_n = 1'b1;
    repeat (6) applyStimulus(1, 1, 0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
